// File: rtl/l1i_pkg.sv
// l1i_pkg: shared constants for the L1 I-cache refill data path.
//   - WORD_W / BEATS / OFF_W : default word width, beats per line, word-offset width
//   - clogb2                 : bits needed to hold a value (minimum 1)
//   - S_IDLE..S_WRITE        : 2-bit refill FSM encodings
package l1i_pkg;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if (v >= (1 << i)) r = i + 1;
    return (r == 0) ? 1 : r;
  endfunction

  localparam int WORD_W = 32;
  localparam int BEATS  = 4;
  localparam int OFF_W  = clogb2(BEATS - 1);

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

endpackage

// File: rtl/l1i_data_ram.sv
// l1i_data_ram: single-write, single-read line array with a registered read port.
//   clk, nrst        : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port, written at the clock edge
//   re_i/raddr_i     : read request; rdata_o updates one cycle later, holds otherwise
//   rdata_o          : registered read data (0 after reset)
// The storage itself is never reset. A read and write to the same address in
// the same cycle returns the previous contents.
module l1i_data_ram #(
  parameter int AW = 6,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  import l1i_pkg::*;

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l1_i_refill_data.sv
// l1_i_refill_data: L1 I-cache refill data path and data array.
//   Collects the L2 beat stream after read_L1_L2, flags a full line on
//   ready_L2_L1 (one-cycle pulse), writes it on refill into {wr_index_i, wr_way_i},
//   and serves word reads with one cycle of latency.
// Ports:
//   clk, nrst                 : clock, async active-low reset
//   read_L1_L2                : line request (level)
//   l2_valid_i, l2_data_i     : L2 beat stream, beat k = line word k
//   ready_L2_L1               : line assembled pulse
//   refill, wr_index_i, wr_way_i : array write strobe and target
//   rd_en_i, rd_index_i, rd_way_i, rd_offset_i : word read request
//   rd_data_o, rd_valid_o     : read data / valid (next cycle)
//   err_o                     : sticky protocol error (stray beat or stray refill)
// Optional build macro L1I_PARITY_EN adds one even-parity bit per stored word,
//   input perr_inj_i (corrupt parity of the next refill write) and output rd_perr_o.
module l1_i_refill_data #(
  parameter int INUM   = 5,
  parameter int WAY    = 2,
  parameter int WORD_W = l1i_pkg::WORD_W,
  parameter int BEATS  = l1i_pkg::BEATS,
  parameter int OFF_W  = l1i_pkg::clogb2(BEATS - 1),
  parameter int WAY_W  = l1i_pkg::clogb2(WAY - 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_L1_L2,
  input  logic              l2_valid_i,
  input  logic [WORD_W-1:0] l2_data_i,
  output logic              ready_L2_L1,
  input  logic              refill,
  input  logic [INUM-1:0]   wr_index_i,
  input  logic [WAY_W-1:0]  wr_way_i,
  input  logic              rd_en_i,
  input  logic [INUM-1:0]   rd_index_i,
  input  logic [WAY_W-1:0]  rd_way_i,
  input  logic [OFF_W-1:0]  rd_offset_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              err_o
`ifdef L1I_PARITY_EN
  ,
  input  logic              perr_inj_i,
  output logic              rd_perr_o
`endif
);
  import l1i_pkg::*;

  localparam int LINE_W = BEATS * WORD_W;
`ifdef L1I_PARITY_EN
  localparam int PAR_W  = BEATS;
`else
  localparam int PAR_W  = 0;
`endif
  localparam int DW     = LINE_W + PAR_W;
  localparam int AW     = INUM + WAY_W;

  logic [1:0]                   state_q, state_d;
  logic [OFF_W-1:0]             cnt_q, cnt_d;
  logic [BEATS-1:0][WORD_W-1:0] line_q;
  logic [BEATS-1:0]             beat_we;
  logic                         err_q, err_d;
  logic                         wr_en;
  logic [DW-1:0]                wdata;
  logic [DW-1:0]                rdata;
  logic [BEATS-1:0][WORD_W-1:0] rwords;
  logic [OFF_W-1:0]             rd_off_q;
  logic                         rd_valid_q;

  // Refill FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_we = '0;
    case (state_q)
      S_IDLE: begin
        if (read_L1_L2) begin
          state_d = S_FILL;
          cnt_d   = '0;
        end
      end
      S_FILL: begin
        if (l2_valid_i) begin
          beat_we[cnt_q] = 1'b1;
          // last beat holds the counter so it never wraps inside a line
          if (cnt_q == OFF_W'(BEATS - 1)) state_d = S_DONE;
          else                            cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_WRITE;
      // request may still be high here; only refill moves us on
      S_WRITE: if (refill) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en = refill && (state_q == S_WRITE);
  assign err_d = err_q
               | (l2_valid_i && (state_q != S_FILL))
               | (refill     && (state_q != S_WRITE));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Line buffer: pure data, a discarded partial line is never written out
  always_ff @(posedge clk) begin
    for (int b = 0; b < BEATS; b++)
      if (beat_we[b]) line_q[b] <= l2_data_i;
  end

  assign ready_L2_L1 = (state_q == S_DONE);
  assign err_o       = err_q;

`ifdef L1I_PARITY_EN
  logic             inj_pend_q;
  logic             inj;
  logic [BEATS-1:0] wpar;

  // injection request is remembered until the next array write consumes it
  assign inj = inj_pend_q | perr_inj_i;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)           inj_pend_q <= 1'b0;
    else if (wr_en)      inj_pend_q <= 1'b0;
    else if (perr_inj_i) inj_pend_q <= 1'b1;
  end

  always_comb begin
    for (int b = 0; b < BEATS; b++)
      wpar[b] = (^line_q[b]) ^ inj;
  end

  assign wdata = {wpar, line_q};
`else
  assign wdata = line_q;
`endif

  l1i_data_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk     (clk),
    .nrst    (nrst),
    .we_i    (wr_en),
    .waddr_i ({wr_index_i, wr_way_i}),
    .wdata_i (wdata),
    .re_i    (rd_en_i),
    .raddr_i ({rd_index_i, rd_way_i}),
    .rdata_o (rdata)
  );

  // Offset is captured with the read so the word select holds with the data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_off_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_off_q <= rd_offset_i;
    end
  end

  assign rwords     = rdata[LINE_W-1:0];
  assign rd_data_o  = rwords[rd_off_q];
  assign rd_valid_o = rd_valid_q;

`ifdef L1I_PARITY_EN
  logic [BEATS-1:0] rpar;
  assign rpar      = rdata[DW-1:LINE_W];
  assign rd_perr_o = rd_valid_q & (^{rwords[rd_off_q], rpar[rd_off_q]});
`endif

endmodule

// File: doc/l1_i_refill_data.md
# l1_i_refill_data

Instruction-side L1 refill data path and data array. It sits between the L2 response channel and the L1 I-cache tag controller. It collects the beat stream L2 returns after a `read_L1_L2` request, assembles a full line, and signals line completion to the controller on `ready_L2_L1`. On the controller's `refill` pulse it writes the line into the selected way, and it serves instruction-word reads to the fetch stage with one cycle of latency.

## Interface
- `INUM`, 5: set index width; must match the tag controller.
- `WAY`, 2: associativity; way select width is clogb2(WAY-1).
- `WORD_W`, 32: instruction word and L2 beat width.
- `BEATS`, 4: beats per line; line width is `BEATS*WORD_W`, and `BEATS` must be a power of two ≥ 2.
- `OFF_W`, clogb2(BEATS-1): word-offset width.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `read_L1_L2`  in  1  line request from the tag controller; level, registered at the source.
- `l2_valid_i`  in  1  L2 data beat valid.
- `l2_data_i`  in  WORD_W  L2 data beat; beat k carries line word k.
- `ready_L2_L1`  out  1  line-assembled pulse to the tag controller.
- `refill`  in  1  write strobe from the tag controller.
- `wr_index_i`  in  INUM  set index for the refill write.
- `wr_way_i`  in  clogb2(WAY-1)  way for the refill write.
- `rd_en_i`  in  1  instruction read request.
- `rd_index_i`  in  INUM  read set index.
- `rd_way_i`  in  clogb2(WAY-1)  read way (hit way).
- `rd_offset_i`  in  OFF_W  word within the line.
- `rd_data_o`  out  WORD_W  instruction word.
- `rd_valid_o`  out  1  `rd_data_o` valid.
- `err_o`  out  1  sticky protocol error; cleared only by reset.

## Operation
- Refill FSM states: S_IDLE, S_FILL, S_DONE, S_WRITE.
- S_IDLE -> S_FILL when `read_L1_L2`=1; the beat counter clears to 0.
- S_FILL: each cycle with `l2_valid_i`=1 writes `l2_data_i` to line buffer word[cnt], then increments cnt. The beat taken at cnt=BEATS-1 moves the FSM to S_DONE. The counter does not wrap within a line.
- S_DONE: `ready_L2_L1`=1 for exactly this cycle; the FSM then moves unconditionally to S_WRITE.
- S_WRITE: `read_L1_L2` is ignored, because the controller's registered request may still be high here. When `refill`=1, DATA[{wr_index_i, wr_way_i}] <= line buffer, with word 0 in bits [WORD_W-1:0]. The FSM then returns to S_IDLE.
- `l2_valid_i`=1 in any state other than S_FILL: the beat is dropped and `err_o` is set.
- `refill`=1 outside S_WRITE: no array write, and `err_o` is set.
- Read path: when `rd_en_i`=1, `rd_data_o` <= DATA[{rd_index_i, rd_way_i}] word `rd_offset_i`, and `rd_valid_o`=1 in the next cycle. When `rd_en_i`=0, `rd_valid_o`=0 in the next cycle and `rd_data_o` holds its value.
- Read and refill write to the same entry in the same cycle: the read returns the old data (read-before-write).
- Data array contents are not reset and not cleared by flush; line validity belongs to the tag controller.

## Timing
- Reset values: `ready_L2_L1`=0, `rd_valid_o`=0, `rd_data_o`=0, `err_o`=0, FSM=S_IDLE, cnt=0.
- Reset during S_FILL, S_DONE or S_WRITE returns to S_IDLE. The partial line is discarded and no write occurs.
- Cycle t: `read_L1_L2` rises. Cycle t+1: S_FILL, and beats are accepted from this cycle on.
- The final beat accepted at cycle f gives `ready_L2_L1`=1 at f+1. The controller pulses `refill` at f+2, and the array is written at the f+2 clock edge.
- Minimum line turnaround from request to array write is BEATS+3 cycles.
- Read latency is 1 cycle, with no back-pressure.

## Configuration
- `L1I_PARITY_EN` defined:
  - One even-parity bit is stored per word on every refill write.
  - An output `rd_perr_o` (1 bit, reset 0) asserts alongside `rd_valid_o` when the recomputed parity mismatches.
  - An input `perr_inj_i` inverts the stored parity bits of the next refill write.
- `L1I_PARITY_EN` undefined: no parity storage and no `rd_perr_o`/`perr_inj_i` ports.

## Structure
- Package `l1i_pkg`: FSM state encodings (2 bits), `WORD_W`, `BEATS`, `OFF_W`, and the clogb2 function.
- Sub-module `l1i_data_ram`: a single-write, single-read registered array of depth `WAY << INUM` and width line(+parity). The FSM, beat counter and line buffer stay in the top level.

## Test plan
- Refill into index 3, way 1 with beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 (one per cycle), then `refill`; next, read offset 2 -> `rd_data_o`=0x33333333 one cycle after `rd_en_i`, with `ready_L2_L1` high for exactly 1 cycle.
- Beats with gaps (valid 1,0,1,0,1,1) -> line assembled in order; `ready_L2_L1` rises the cycle after the 4th beat.
- Assert `nrst` after 2 beats, then run a fresh refill with 0xA0..0xA3 -> the array holds only 0xA0..0xA3 and `err_o`=0.
- `l2_valid_i`=1 in S_IDLE -> `err_o`=1 and stays 1; no array write.
- Read and refill of index 0, way 0 in the same cycle -> old word returned; a read one cycle later returns the new word.
- With `L1I_PARITY_EN`: refill with `perr_inj_i`=1, then read any offset -> `rd_perr_o`=1; a clean refill then gives `rd_perr_o`=0.
